// File: rtl/add_4b.sv
// 4-bit carry-lookahead adder slice with registered sum and group generate/propagate
// outputs, so a second-level lookahead unit can chain eight slices into 32 bits.
module add_4b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       C0,
    input  logic [3:0] ai,
    input  logic [3:0] bi,
    output logic [3:0] s,
    output logic       GG,
    output logic       GP
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic [3:0] s_d, s_q;
    logic       gg_d, gg_q;
    logic       gp_d, gp_q;

    // Every carry is a flat sum of products over G, P and C0, so no carry
    // waits on a lower carry.
    always_comb begin
        g    = ai & bi;
        p    = ai ^ bi;
        c[0] = C0;
        c[1] = g[0] | (p[0] & C0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & C0);
        s_d  = p ^ c;
        gg_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        gp_d = &p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= 4'h0;
            gg_q <= 1'b0;
            gp_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            gg_q <= gg_d;
            gp_q <= gp_d;
        end
    end

    assign s  = s_q;
    assign GG = gg_q;
    assign GP = gp_q;

endmodule

// File: tb/tb_add_4b.sv
// Bench for add_4b: an arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results.
module tb_add_4b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       C0 = 1'b0;
    logic [3:0] ai = 4'h0;
    logic [3:0] bi = 4'h0;
    logic [3:0] s;
    logic       GG;
    logic       GP;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    logic [3:0] exp_s;
    logic       exp_gg;
    logic       exp_gp;

    add_4b dut (
        .clk  (clk),
        .rst_n(rst_n),
        .C0   (C0),
        .ai   (ai),
        .bi   (bi),
        .s    (s),
        .GG   (GG),
        .GP   (GP)
    );

    always #25 clk = ~clk;

    // Reference model: plain integer arithmetic on the captured inputs.
    function automatic logic [5:0] golden(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin);
        int sum, sum0;
        sum  = int'(a) + int'(b) + int'(cin);
        sum0 = int'(a) + int'(b);
        return {sum[3:0], sum0 >= 16, (a ^ b) == 4'hF};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_s  <= 4'h0;
            exp_gg <= 1'b0;
            exp_gp <= 1'b0;
        end else begin
            {exp_s, exp_gg, exp_gp} <= golden(ai, bi, C0);
        end
    end

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got s=%h GG=%b GP=%b, want s=%h GG=%b GP=%b",
                     name, act[5:2], act[1], act[0], req[5:2], req[1], req[0]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("model", {s, GG, GP}, {exp_s, exp_gg, exp_gp});
    end

    // Drive one vector, take one edge, pin both DUT and model to a literal.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [5:0] req, input string name);
        @(negedge clk);
        ai = a; bi = b; C0 = cin;
        @(posedge clk);
        #1;
        check(name, {s, GG, GP}, req);
        check({name, "_model"}, {exp_s, exp_gg, exp_gp}, req);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        ai = 4'h7; bi = 4'h9; C0 = 1'b1;
        #5 rst_n = 1'b0;
        #1 check("async_reset", {s, GG, GP}, 6'b0000_0_0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 check("reset_held", {s, GG, GP}, 6'b0000_0_0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("reset_release", {s, GG, GP}, {4'h1, 1'b1, 1'b0});

        apply(4'h3, 4'h5, 1'b0, {4'h8, 1'b0, 1'b0}, "add_3_5");
        apply(4'hF, 4'h1, 1'b0, {4'h0, 1'b1, 1'b0}, "wrap_F_1");
        apply(4'hA, 4'h5, 1'b0, {4'hF, 1'b0, 1'b1}, "prop_A_5_c0");
        apply(4'hA, 4'h5, 1'b1, {4'h0, 1'b0, 1'b1}, "prop_A_5_c1");
        apply(4'h0, 4'h0, 1'b0, {4'h0, 1'b0, 1'b0}, "zero");
        apply(4'h2, 4'h2, 1'b0, {4'h4, 1'b0, 1'b0}, "b2b_2_2");
        apply(4'h8, 4'h8, 1'b0, {4'h0, 1'b1, 1'b0}, "b2b_8_8");
        apply(4'hF, 4'hF, 1'b1, {4'hF, 1'b1, 1'b0}, "max_c1");

        // Reset mid-operation drops the pending result.
        @(negedge clk);
        ai = 4'h3; bi = 4'h5; C0 = 1'b0;
        #5 rst_n = 1'b0;
        #1 check("midop_reset", {s, GG, GP}, 6'b0000_0_0);
        @(posedge clk);
        #1 check("midop_reset_held", {s, GG, GP}, 6'b0000_0_0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("midop_release", {s, GG, GP}, {4'h8, 1'b0, 1'b0});

        for (int cin = 0; cin < 2; cin++) begin
            for (int k = 0; k < 41; k++) begin
                @(negedge clk);
                ai = 4'($urandom_range(0, 15));
                bi = 4'($urandom_range(0, 15));
                C0 = cin[0];
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
